// File: rtl/axis_cobs_pkg.sv
// Shared definitions for the COBS stream blocks (framer, encoder, decoder):
// delimiter byte, default sizing, framer state encoding and output beat layout.
package axis_cobs_pkg;

    localparam logic [7:0] COBS_DELIM       = 8'h00;
    localparam int         COBS_MAX_LEN_DEF = 256;
    localparam int         COBS_TIMEOUT_DEF = 1024;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } cobs_beat_t;

endpackage

// File: rtl/axis_cobs_framer.sv
// Splits a 0x00-delimited byte stream into tlast-terminated AXI-Stream frames.
// Optional idle timeout is built in when COBS_FRAMER_TIMEOUT_EN is defined.
module axis_cobs_framer
    import axis_cobs_pkg::*;
#(
    parameter int MAX_LEN = COBS_MAX_LEN_DEF,
    parameter int TIMEOUT = COBS_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser
);

    localparam int CW = $clog2(MAX_LEN + 1);

    logic [1:0]    state, state_nxt;
    logic [7:0]    hold_data, hold_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          push;
    cobs_beat_t    push_beat;
    logic          hold_valid, out_free, accept, is_delim;
    logic          timeout_fire;

    assign hold_valid    = (state == ST_HOLD);
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    // Gated by rst_n so no byte is claimed as accepted while held in reset.
    assign s_axis_tready = rst_n && (!hold_valid || out_free);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign is_delim      = (s_axis_tdata == COBS_DELIM);

`ifdef COBS_FRAMER_TIMEOUT_EN
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] IDLE_LIM = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_cnt;

    // Saturates at the limit so a busy output stage just defers the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!hold_valid || accept || timeout_fire) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LIM) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_fire = hold_valid && !accept && out_free && (idle_cnt == IDLE_LIM);
`else
    assign timeout_fire = 1'b0;
    // TIMEOUT carries no meaning without the timer.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_data;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_beat = '{data: hold_data, last: 1'b0, user: 1'b0};
        if (timeout_fire) begin
            push           = 1'b1;
            push_beat.last = 1'b1;
            push_beat.user = 1'b1;
            state_nxt      = ST_DROP;
            cnt_nxt        = '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!is_delim) begin
                        hold_nxt  = s_axis_tdata;
                        cnt_nxt   = CW'(1);
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Accepting in HOLD implies the output stage is free.
                    push = 1'b1;
                    if (is_delim) begin
                        push_beat.last = 1'b1;
                        state_nxt      = ST_IDLE;
                        cnt_nxt        = '0;
                    end else if (cnt == CW'(MAX_LEN)) begin
                        push_beat.last = 1'b1;
                        push_beat.user = 1'b1;
                        state_nxt      = ST_DROP;
                        cnt_nxt        = '0;
                    end else begin
                        hold_nxt = s_axis_tdata;
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
                ST_DROP: begin
                    if (is_delim) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_data <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            hold_data <= hold_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Output register reloads on the same edge its old beat is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (push) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= push_beat.data;
            m_axis_tlast  <= push_beat.last;
            m_axis_tuser  <= push_beat.user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_cobs_framer.sv
// Randomized bench for axis_cobs_framer against a frame-level reference model.
module tb_axis_cobs_framer;

    localparam int MAX_LEN = 4;
    localparam int TIMEOUT = 8;
`ifdef COBS_FRAMER_TIMEOUT_EN
    localparam int STALL = 4;
`else
    localparam int STALL = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    always #5 clk = ~clk;

    axis_cobs_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [9:0]  exp_q[$];
    bit          stall_force = 1'b0;
    bit          saw_rdy_low = 1'b0;
    bit          prev_stall = 1'b0;
    logic [10:0] prev_word = '0;
    int          low_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Frame-level rules: split on 0x00, drop empty frames, cut frames longer
    // than MAX_LEN (flagged bad) and skip the rest up to the next 0x00.
    task automatic model(input logic [7:0] bytes[$]);
        logic [7:0] frm[$];
        bit         drop = 1'b0;
        foreach (bytes[i]) begin
            if (drop) begin
                if (bytes[i] == 8'h00) drop = 1'b0;
            end else if (bytes[i] == 8'h00) begin
                foreach (frm[k]) exp_q.push_back({frm[k], k == frm.size() - 1, 1'b0});
                frm.delete();
            end else if (frm.size() == MAX_LEN) begin
                foreach (frm[k]) exp_q.push_back({frm[k], k == frm.size() - 1, k == frm.size() - 1});
                frm.delete();
                drop = 1'b1;
            end else begin
                frm.push_back(bytes[i]);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 8'($urandom);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        #1;
        while (!s_axis_tready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) chk("s_accept_bound", 32'(guard), 32'd0);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor and downstream ready generator.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && !s_axis_tready) saw_rdy_low = 1'b1;
        if (rst_n && prev_stall)
            chk("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(prev_word));
        if (stall_force)        m_axis_tready = 1'b0;
        else if (low_run >= 2)  m_axis_tready = 1'b1;
        else                    m_axis_tready = ($urandom_range(0, 3) != 0);
        low_run = m_axis_tready ? 0 : low_run + 1;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'h3ff);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(e));
            end
        end
        prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end

    initial begin
        logic [7:0] q[$];
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
        chk("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
        chk("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        q = {8'h11, 8'h22, 8'h00};
        model(q); send_q(q); drain("drain_basic");

        q = {8'h00, 8'h00, 8'h05, 8'h00};
        model(q); send_q(q); drain("drain_empty");

        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h07, 8'h00};
        model(q); send_q(q); drain("drain_overflow");

        q = {8'h11, 8'h22, 8'h33, 8'h00};
        model(q);
        saw_rdy_low = 1'b0;
        fork
            send_q(q);
            begin
                repeat (2) @(negedge clk);
                stall_force = 1'b1;
                repeat (STALL) @(negedge clk);
                stall_force = 1'b0;
            end
        join
        drain("drain_stall");
        chk("s_tready_dropped", 32'(saw_rdy_low), 32'd1);

        // Partial frame killed by reset while the output is held off.
        stall_force = 1'b1;
        q = {8'h11, 8'h22};
        send_q(q);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_force = 1'b0;
        q = {8'h00, 8'hAA, 8'h00};
        model(q); send_q(q); drain("drain_after_reset");

        q.delete();
        for (int f = 0; f < 60; f++) begin
            int len = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(1, 255)));
            q.push_back(8'h00);
        end
        model(q); send_q(q); drain("drain_random");

`ifdef COBS_FRAMER_TIMEOUT_EN
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        exp_q.push_back({8'h22, 1'b1, 1'b1});
        q = {8'h11, 8'h22};
        send_q(q);
        repeat (20) @(negedge clk);
        drain("drain_timeout");
        exp_q.push_back({8'h44, 1'b1, 1'b0});
        q = {8'h33, 8'h00, 8'h44, 8'h00};
        send_q(q);
        drain("drain_post_timeout");
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_cobs_framer.md
AXIS_COBS_FRAMER -- requirements
Module: axis_cobs_framer

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 256: maximum bytes per output frame; range 2..65535.
REQ-002 SHALL provide parameter TIMEOUT, default 1024: idle-cycle limit; used only when COBS_FRAMER_TIMEOUT_EN is defined.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  8  raw 0x00-delimited COBS byte stream.
- s_axis_tvalid  input  1  input byte valid.
- s_axis_tready  output  1  input byte accepted.
- m_axis_tdata  output  8  framed byte, delimiter stripped.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  downstream ready (the COBS decoder).
- m_axis_tlast  output  1  last byte of frame.
- m_axis_tuser  output  1  frame bad (truncated by overflow or timeout).

Function
REQ-005 SHALL split the input stream on 0x00 bytes into tlast-terminated AXI-Stream frames; 0x00 bytes SHALL never be output.
REQ-006 SHALL use a one-byte hold register plus a registered output stage; a held byte SHALL move to output only after the next input byte is accepted.
REQ-007 SHALL move the held byte with tlast=0 if the next byte is non-zero, and with tlast=1, tuser=0 if it is 0x00.
REQ-008 Latency: a byte SHALL appear on m_axis one cycle after acceptance of its successor byte.
REQ-009 SHALL drive s_axis_tready = !hold_valid || !m_axis_tvalid || m_axis_tready.
REQ-010 Once m_axis_tvalid is asserted, data, tlast and tuser SHALL hold stable until m_axis_tready is high.
REQ-011 SHALL use states IDLE (hold empty), HOLD (hold valid) and DROP (discarding).
REQ-012 IDLE: a non-zero byte SHALL load hold and go to HOLD; a 0x00 byte SHALL be discarded (empty frame, no output).
REQ-013 HOLD: a non-zero byte SHALL push hold and reload it; a 0x00 byte SHALL push hold with tlast=1 and go to IDLE.
REQ-014 SHALL keep a frame byte counter of width $clog2(MAX_LEN+1), cleared on each frame start.
REQ-015 Overflow: when a non-zero byte would be frame byte MAX_LEN+1, the held byte SHALL be pushed with tlast=1, tuser=1, the new byte discarded, and the state SHALL go to DROP.
REQ-016 DROP: non-zero bytes SHALL be discarded with s_axis_tready=1; a 0x00 byte SHALL return the block to IDLE.
REQ-017 Output on the same cycle as input: the output register SHALL load the new value while the old one is consumed, with no bubble and no loss.

Reset
REQ-018 Asserting rst_n low SHALL set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0 and s_axis_tready=0 (while low), state to IDLE, and counters to 0.
REQ-019 Reset mid-frame SHALL discard the partial frame with no tlast emitted.
REQ-020 After release, the first 0x00 byte SHALL be handled as in IDLE.

Configuration
REQ-021 With COBS_FRAMER_TIMEOUT_EN defined, the block SHALL count consecutive HOLD cycles with no input accepted.
REQ-022 With COBS_FRAMER_TIMEOUT_EN defined, when that count reaches TIMEOUT and the output stage is free, the block SHALL push hold with tlast=1, tuser=1 and go to DROP.
REQ-023 With COBS_FRAMER_TIMEOUT_EN undefined, the block SHALL have no timer logic and SHALL ignore TIMEOUT.

Structure
REQ-024 Package axis_cobs_pkg SHALL hold the state encoding, COBS_DELIM=8'h00, and the default MAX_LEN and TIMEOUT values, shared with axis_cobs_encode and axis_cobs_decode.
REQ-025 The block SHALL be one flat module with no sub-module; the hold register and output register SHALL be inline.

Verification
REQ-026 Input 11 22 00 with m_axis_tready=1 -> output 11(tlast=0), 22(tlast=1, tuser=0).
REQ-027 Input 00 00 05 00 -> exactly one frame: 05(tlast=1); empty frames produce no output.
REQ-028 With MAX_LEN=4, input 01 02 03 04 05 06 00 07 00 -> output 01 02 03 04(tlast=1, tuser=1), then 07(tlast=1, tuser=0).
REQ-029 Input 11 22 33 00 with m_axis_tready low 10 cycles mid-frame -> s_axis_tready deasserts; output 11 22 33(tlast=1) in order, no loss or duplicates.
REQ-030 Input 11 22, then rst_n low for 2 cycles, then AA 00 -> outputs only AA(tlast=1); 11 and 22 never appear.
REQ-031 With COBS_FRAMER_TIMEOUT_EN defined and TIMEOUT=8, input 11 22 then idle 8 cycles -> 11, 22(tlast=1, tuser=1); later 33 00 is discarded until the 00, then normal framing resumes.
